// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access codes, FSM states,
// bus field bundle and byte/halfword lane helpers.
package mem_pkg;

  localparam logic [2:0] FC_LB  = 3'b000;
  localparam logic [2:0] FC_LBU = 3'b001;
  localparam logic [2:0] FC_LH  = 3'b010;
  localparam logic [2:0] FC_LHU = 3'b011;
  localparam logic [2:0] FC_LW  = 3'b100;
  localparam logic [2:0] FC_SB  = 3'b101;
  localparam logic [2:0] FC_SH  = 3'b110;
  localparam logic [2:0] FC_SW  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = bus_t'(70'h0);

  function automatic logic fc_is_store(input logic [2:0] fc);
    return (fc == FC_SB) || (fc == FC_SH) || (fc == FC_SW);
  endfunction

  function automatic logic fc_is_half(input logic [2:0] fc);
    return (fc == FC_LH) || (fc == FC_LHU) || (fc == FC_SH);
  endfunction

  function automatic logic fc_is_word(input logic [2:0] fc);
    return (fc == FC_LW) || (fc == FC_SW);
  endfunction

  function automatic logic fc_misaligned(input logic [2:0] fc, input logic [1:0] addr_lo);
    return (fc_is_half(fc) && addr_lo[0]) || (fc_is_word(fc) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane steering: store strobes and replicated write data on the
// request side, load lane extraction and extension on the response side.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [2:0]  wr_fc,
  input  logic [1:0]  wr_addr_lo,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_fc,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rd_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        is_store
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign misalign = fc_misaligned(wr_fc, wr_addr_lo);
  assign is_store = fc_is_store(wr_fc);
  assign byte_s   = rd_word[{rd_addr_lo, 3'b000} +: 8];
  assign half_s   = rd_addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  // Store side: loads drive no strobes and zero data.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    case (wr_fc)
      FC_SB: begin
        wstrb = 4'b0001 << wr_addr_lo;
        wdata = {4{wr_data[7:0]}};
      end
      FC_SH: begin
        wstrb = wr_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
      FC_SW: begin
        wstrb = 4'b1111;
        wdata = wr_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (rd_fc)
      FC_LB:   rdata_ext = ext8(byte_s, 1'b1);
      FC_LBU:  rdata_ext = ext8(byte_s, 1'b0);
      FC_LH:   rdata_ext = ext16(half_s, 1'b1);
      FC_LHU:  rdata_ext = ext16(half_s, 1'b0);
      FC_LW:   rdata_ext = rd_word;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: drives a request/grant/data-ok bus, holds
// the pipeline while the access is in flight and returns the extended load word.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_fc,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             bus_err_q, bus_err_d;
  bus_t             bus_q, bus_d;
  logic [2:0]       fc_q, fc_d;
  logic [1:0]       addr_lo_q, addr_lo_d;

  logic [3:0]  lane_wstrb_s;
  logic [31:0] lane_wdata_s;
  logic [31:0] lane_rdata_s;
  logic        misalign_s;
  logic        is_store_s;
  logic        idle_s;
  logic        start_s;
  logic        timeout_s;

  dmem_lane u_lane (
    .wr_fc      (req_fc),
    .wr_addr_lo (req_addr[1:0]),
    .wr_data    (req_wdata),
    .rd_fc      (fc_q),
    .rd_addr_lo (addr_lo_q),
    .rd_word    (mem_rdata),
    .wstrb      (lane_wstrb_s),
    .wdata      (lane_wdata_s),
    .rdata_ext  (lane_rdata_s),
    .misalign   (misalign_s),
    .is_store   (is_store_s)
  );

  assign idle_s    = (state_q == ST_IDLE);
  assign start_s   = idle_s & req_valid & ~misalign_s & ~req_flush;
  assign timeout_s = (cnt_q == CNT_LAST);

  // The IDLE cycle that launches an access must already hold the pipeline.
  assign stall      = start_s | (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign adel       = idle_s & req_valid & misalign_s & ~is_store_s;
  assign ades       = idle_s & req_valid & misalign_s & is_store_s;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = bus_q.req;
  assign mem_wr     = bus_q.wr;
  assign mem_wstrb  = bus_q.wstrb;
  assign mem_addr   = bus_q.addr;
  assign mem_wdata  = bus_q.wdata;

  // Next-state, timeout counter and bus field computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    bus_d        = bus_q;
    fc_d         = fc_q;
    addr_lo_d    = addr_lo_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = CNT_ZERO;
        drop_d = 1'b0;
        if (start_s) begin
          state_d     = ST_REQ;
          bus_d.req   = 1'b1;
          bus_d.wr    = is_store_s;
          bus_d.wstrb = lane_wstrb_s;
          bus_d.addr  = {req_addr[31:2], 2'b00};
          bus_d.wdata = lane_wdata_s;
          fc_d        = req_fc;
          addr_lo_d   = req_addr[1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        // Once granted the bus owns the access, so a late flush only drops the result.
        if (mem_gnt) begin
          state_d   = ST_WAIT;
          bus_d.req = 1'b0;
          drop_d    = drop_q | req_flush;
        end else if (req_flush) begin
          state_d = ST_IDLE;
          bus_d   = BUS_IDLE;
        end else if (timeout_s) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0000_0000;
          bus_d     = BUS_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        cnt_d  = cnt_q + CNT_ONE;
        drop_d = drop_q | req_flush;
        if (mem_rvalid) begin
          state_d      = ST_DONE;
          resp_valid_d = ~(drop_q | req_flush);
          rdata_d      = lane_rdata_s;
          bus_d        = BUS_IDLE;
        end else if (timeout_s) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0000_0000;
          bus_d     = BUS_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        drop_d  = 1'b0;
        bus_d   = BUS_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      drop_q       <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      bus_q        <= BUS_IDLE;
      fc_q         <= 3'b000;
      addr_lo_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      bus_err_q    <= bus_err_d;
      bus_q        <= bus_d;
      fc_q         <= fc_d;
      addr_lo_q    <= addr_lo_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a bus model feeds each access, a scoreboard
// queue holds expected responses and a monitor checks every response pulse.
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_flush;
  logic [2:0]  req_fc;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, adel, ades, bus_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   mis_cnt = 0;

  dmem_responder #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_fc(req_fc), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_flush(req_flush),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .adel(adel), .ades(ades), .bus_err(bus_err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_flush  = 1'b0;
    req_fc     = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // Scoreboard monitor: every response or error pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst && (resp_valid || bus_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {30'h0, bus_err, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_err", {31'h0, bus_err}, {31'h0, e.err});
        check("resp_valid", {31'h0, resp_valid}, {31'h0, ~e.err});
        if (!e.err) check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // One access with a reactive bus: grant after gnt_dly request cycles, data
  // rv_dly cycles after the grant, optional flush on cycle flush_cyc.
  task automatic txn(input string name, input logic [2:0] fc, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int gnt_dly, input int rv_dly, input int flush_cyc,
                     input int exp_stall, input int exp_reqs, input logic exp_wr,
                     input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_addr);
    int stall_n = 0, req_n = 0, reqc = 0, waitc = 0;
    bit granted = 1'b0, flushed = 1'b0, done = 1'b0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
    logic [3:0]  cap_strb = 4'h0;
    logic        cap_wr = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      req_valid  = !flushed;
      req_fc     = fc;
      req_addr   = addr;
      req_wdata  = wdata;
      req_flush  = (c == flush_cyc);
      mem_gnt    = mem_req && (reqc == gnt_dly);
      mem_rvalid = granted && (waitc == rv_dly);
      mem_rdata  = rdata;
      #1;
      if (mem_req) begin
        if (req_n == 0) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_strb = mem_wstrb; cap_wr = mem_wr;
        end
        req_n++;
        reqc++;
      end
      if (stall) stall_n++;
      else if (c > 0) done = 1'b1;
      if (mem_gnt) granted = 1'b1;
      if (granted) waitc++;
      if (c == flush_cyc) flushed = 1'b1;
    end
    if (!done) begin
      vec_cnt++;
      mis_cnt++;
      $display("FAIL %s_complete: stall still high after 40 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, stall_n, exp_stall);
    check({name, "_req_cycles"}, req_n, exp_reqs);
    if (req_n > 0) begin
      check({name, "_mem_addr"}, cap_addr, exp_addr);
      check({name, "_mem_wstrb"}, {28'h0, cap_strb}, {28'h0, exp_strb});
      check({name, "_mem_wdata"}, cap_wdata, exp_wdata);
      check({name, "_mem_wr"}, {31'h0, cap_wr}, {31'h0, exp_wr});
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic misal(input string name, input logic [2:0] fc, input logic [31:0] addr,
                       input logic exp_adel, input logic exp_ades);
    bit req_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_fc = fc; req_addr = addr; req_wdata = 32'h5A5A_5A5A;
    #1;
    check({name, "_adel"}, {31'h0, adel}, {31'h0, exp_adel});
    check({name, "_ades"}, {31'h0, ades}, {31'h0, exp_ades});
    check({name, "_stall"}, {31'h0, stall}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      #1;
      if (mem_req) req_seen = 1'b1;
    end
    check({name, "_no_mem_req"}, {31'h0, req_seen}, 32'h0);
    drive_idle();
    #1;
    check({name, "_flag_clears"}, {30'h0, adel, ades}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ctrl", {25'h0, stall, resp_valid, adel, ades, bus_err, mem_req, mem_wr}, 32'h0);
    check("reset_bus", {mem_wstrb, mem_addr[27:0]} | mem_wdata | resp_rdata, 32'h0);

    // Stores: strobes, lane replication, word-aligned address.
    expect_resp(1'b0, 32'h0);
    txn("sb_103", FC_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0, 1, -1,
        3, 1, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0000_0100);
    expect_resp(1'b0, 32'h0);
    txn("sh_106", FC_SH, 32'h0000_0106, 32'h1234_BEEF, 32'h0, 0, 1, -1,
        3, 1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0104);
    expect_resp(1'b0, 32'h0);
    txn("sw_108", FC_SW, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0, 0, 1, -1,
        3, 1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0108);

    // Loads: lane selection and sign/zero extension.
    expect_resp(1'b0, 32'hFFFF_FF80);
    txn("lb_202", FC_LB, 32'h0000_0202, 32'h5555_5555, 32'h1280_3456, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'h0000_0080);
    txn("lbu_202", FC_LBU, 32'h0000_0202, 32'h0, 32'h1280_3456, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'h0000_1280);
    txn("lh_202", FC_LH, 32'h0000_0202, 32'h0, 32'h1280_3456, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'hFFFF_ABCD);
    txn("lh_200", FC_LH, 32'h0000_0200, 32'h0, 32'h1234_ABCD, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'h0000_ABCD);
    txn("lhu_200", FC_LHU, 32'h0000_0200, 32'h0, 32'h1234_ABCD, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'h0000_0034);
    txn("lb_201", FC_LB, 32'h0000_0201, 32'h0, 32'h1280_3456, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);
    expect_resp(1'b0, 32'h1280_3456);
    txn("lw_200", FC_LW, 32'h0000_0200, 32'h0, 32'h1280_3456, 0, 1, -1,
        3, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0200);

    // Misaligned accesses never reach the bus.
    misal("lh_1001", FC_LH, 32'h0000_1001, 1'b1, 1'b0);
    misal("sw_1002", FC_SW, 32'h0000_1002, 1'b0, 1'b1);

    // Slow bus: grant after two cycles, data three cycles after grant.
    expect_resp(1'b0, 32'hCAFE_F00D);
    txn("lw_slow", FC_LW, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 2, 3, -1,
        7, 3, 1'b0, 4'b0000, 32'h0, 32'h0000_0204);

    // Flush before grant abandons; flush after grant drops the result.
    txn("flush_req", FC_LW, 32'h0000_0300, 32'h0, 32'h1111_1111, 5, 1, 1,
        2, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0300);
    txn("flush_wait", FC_LW, 32'h0000_0304, 32'h0, 32'h2222_2222, 0, 3, 2,
        5, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0304);

    // No grant ever: eight bus cycles then an error pulse.
    expect_resp(1'b1, 32'h0);
    txn("timeout", FC_SW, 32'h0000_0400, 32'h0000_0001, 32'h0, 99, 1, -1,
        9, 8, 1'b1, 4'b1111, 32'h0000_0001, 32'h0000_0400);

    // Asynchronous reset while waiting for data.
    @(negedge clk);
    req_valid = 1'b1; req_fc = FC_LW; req_addr = 32'h0000_0500;
    @(negedge clk);
    mem_gnt = mem_req;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("pre_rst_stall", {31'h0, stall}, 32'h1);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {25'h0, stall, resp_valid, adel, ades, bus_err, mem_req, mem_wr}, 32'h0);
    check("rst_mid_bus", {28'h0, mem_wstrb} | mem_addr | mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h3333_3333;
    @(negedge clk);
    drive_idle();

    // Normal access still works afterwards.
    expect_resp(1'b0, 32'h8765_4321);
    txn("lw_after_rst", FC_LW, 32'h0000_0600, 32'h0, 32'h8765_4321, 1, 2, -1,
        5, 2, 1'b0, 4'b0000, 32'h0, 32'h0000_0600);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
